neuron_mac_q312: RTL

//  Serial multiply-accumulate neuron front end feeding the sigmoid lookup stage.
//  - Accumulates bias + sum(x[i]*w[i]) over N_INPUTS beats, all Q3.12 two's complement.
//  - Rounds and saturates the sum, then emits sign-magnitude Q3.12 for the sigmoid LUT:
//    bit15 = sign, bits14:0 = magnitude.
//  - One instance per neuron in the fixed-point XOR network (hidden and output layers).

---
 rtl/neuron_mac_q312.sv | 75 +++++++
 1 files changed

// File: rtl/neuron_mac_q312.sv
// neuron_mac_q312: serial Q3.12 MAC neuron (start/bias in, x/w beats in, rounded saturated sign-magnitude out_data/sat out, busy status)
module neuron_mac_q312 #(
  parameter int N_INPUTS = 2,
  parameter int FRAC_BITS = 12,
  parameter int ACC_W = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic        x_valid,
  output logic        x_ready,
  input  logic [15:0] x_data,
  input  logic [15:0] w_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        sat,
  output logic        busy
);
  localparam int CW = $clog2(N_INPUTS + 1);
  typedef enum logic [1:0] {IDLE, ACC, CONV, OUT} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic signed [ACC_W-1:0] acc, acc_init, rnd, r;
  logic [ACC_W-1:0] a;
  logic signed [31:0] xs, ws, prod;
  logic beat, last, clip;
  logic [14:0] mag;
  assign beat = x_valid & x_ready;
  assign last = cnt == CW'(N_INPUTS - 1);
  assign acc_init = {{(ACC_W-16){bias[15]}}, bias} << FRAC_BITS;
  assign xs = {{16{x_data[15]}}, x_data};
  assign ws = {{16{w_data[15]}}, w_data};
  assign prod = xs * ws;
  assign rnd = acc + ACC_W'(1 << (FRAC_BITS - 1));
  assign r = rnd >>> FRAC_BITS;
  assign a = r[ACC_W-1] ? -r : r;
  assign clip = |a[ACC_W-1:15];
  assign mag = clip ? 15'h7fff : a[14:0];
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? ACC : IDLE;
      ACC:  nxt = (beat && last) ? CONV : ACC;
      CONV: nxt = OUT;
      OUT:  nxt = out_ready ? IDLE : OUT;
    endcase
  end
  always_comb begin
    x_ready = state == ACC;
    out_valid = state == OUT;
    busy = state != IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      out_data <= '0;
      sat <= 1'b0;
    end else if (state == IDLE && start) begin
      acc <= acc_init;
      cnt <= '0;
      sat <= 1'b0;
    end else if (beat) begin
      acc <= acc + {{(ACC_W-32){prod[31]}}, prod};
      cnt <= cnt + 1'b1;
    end else if (state == CONV) begin
      out_data <= {r[ACC_W-1], mag};
      sat <= clip;
    end
endmodule
